// File: rtl/cve2_xif_offload_ctrl.sv
// XIF offload sequencer: walks one instruction through issue, commit, register and result.
// issue_valid_o follows off_req_i by one cycle; valids hold until ready, outcome pulses land one cycle after the handshake.
module cve2_xif_offload_ctrl #(
   parameter int unsigned                X_NUM_RS       = 2,
   parameter int unsigned                X_ID_WIDTH     = 4,
   parameter int unsigned                X_HARTID_WIDTH = 1,
   parameter logic [X_HARTID_WIDTH-1:0]  HARTID         = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,

   input  logic                          off_req_i,
   input  logic [31:0]                   off_instr_i,
   input  logic [32*X_NUM_RS-1:0]        off_rs_i,
   input  logic                          off_kill_i,
   output logic                          off_busy_o,
   output logic                          off_illegal_o,
   output logic                          off_done_o,
   output logic                          wb_we_o,
   output logic [4:0]                    wb_rd_o,
   output logic [31:0]                   wb_data_o,
   output logic                          exc_o,
   output logic [5:0]                    exccode_o,
   output logic                          protocol_err_o,

   output logic                          issue_valid_o,
   input  logic                          issue_ready_i,
   output logic [31:0]                   issue_instr_o,
   output logic [X_ID_WIDTH-1:0]         issue_id_o,
   output logic [X_HARTID_WIDTH-1:0]     issue_hartid_o,
   input  logic                          issue_accept_i,
   input  logic                          issue_writeback_i,
   input  logic [X_NUM_RS-1:0]           issue_register_read_i,

   output logic                          commit_valid_o,
   output logic [X_ID_WIDTH-1:0]         commit_id_o,
   output logic                          commit_kill_o,

   output logic                          register_valid_o,
   input  logic                          register_ready_i,
   output logic [X_ID_WIDTH-1:0]         register_id_o,
   output logic [32*X_NUM_RS-1:0]        register_rs_o,
   output logic [X_NUM_RS-1:0]           register_rs_valid_o,

   input  logic                          result_valid_i,
   output logic                          result_ready_o,
   input  logic [X_ID_WIDTH-1:0]         result_id_i,
   input  logic [31:0]                   result_data_i,
   input  logic [4:0]                    result_rd_i,
   input  logic                          result_we_i,
   input  logic                          result_exc_i,
   input  logic [5:0]                    result_exccode_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_COMMIT,
      S_REG,
      S_RESULT
   } state_e;

   state_e                    state_q;
   logic [X_ID_WIDTH-1:0]     id_cnt_q;
   logic [X_ID_WIDTH-1:0]     id_cnt_d;
   logic [X_ID_WIDTH-1:0]     cur_id_q;
   logic [31:0]               instr_q;
   logic [32*X_NUM_RS-1:0]    rs_q;
   logic                      kill_q;
   logic                      wb_flag_q;
   logic [X_NUM_RS-1:0]       rd_flags_q;
   logic                      issue_valid_q;
   logic                      commit_valid_q;
   logic                      commit_kill_q;
   logic                      register_valid_q;
   logic                      result_ready_q;
   logic                      illegal_q;
   logic                      done_q;
   logic                      wb_we_q;
   logic [4:0]                wb_rd_q;
   logic [31:0]               wb_data_q;
   logic                      exc_q;
   logic [5:0]                exccode_q;
   logic                      perr_q;

   assign id_cnt_d = X_ID_WIDTH'(id_cnt_q + 1'b1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= S_IDLE;
         id_cnt_q         <= '0;
         cur_id_q         <= '0;
         instr_q          <= '0;
         rs_q             <= '0;
         kill_q           <= 1'b0;
         wb_flag_q        <= 1'b0;
         rd_flags_q       <= '0;
         issue_valid_q    <= 1'b0;
         commit_valid_q   <= 1'b0;
         commit_kill_q    <= 1'b0;
         register_valid_q <= 1'b0;
         result_ready_q   <= 1'b0;
         illegal_q        <= 1'b0;
         done_q           <= 1'b0;
         wb_we_q          <= 1'b0;
         wb_rd_q          <= '0;
         wb_data_q        <= '0;
         exc_q            <= 1'b0;
         exccode_q        <= '0;
         perr_q           <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
         wb_we_q   <= 1'b0;
         exc_q     <= 1'b0;
         if (state_q != S_IDLE && off_kill_i) begin
            kill_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (off_req_i) begin
                  instr_q       <= off_instr_i;
                  rs_q          <= off_rs_i;
                  kill_q        <= 1'b0;
                  issue_valid_q <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue_ready_i) begin
                  issue_valid_q <= 1'b0;
                  id_cnt_q      <= id_cnt_d;
                  cur_id_q      <= id_cnt_q;
                  wb_flag_q     <= issue_writeback_i;
                  rd_flags_q    <= issue_register_read_i;
                  if (issue_accept_i) begin
                     // A kill in the handshake cycle itself must still reach the commit.
                     commit_valid_q <= 1'b1;
                     commit_kill_q  <= kill_q | off_kill_i;
                     state_q        <= S_COMMIT;
                  end else begin
                     illegal_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end
            end
            S_COMMIT: begin
               commit_valid_q <= 1'b0;
               commit_kill_q  <= 1'b0;
               if (commit_kill_q) begin
                  state_q <= S_IDLE;
               end else if (|rd_flags_q) begin
                  register_valid_q <= 1'b1;
                  state_q          <= S_REG;
               end else begin
                  result_ready_q <= 1'b1;
                  state_q        <= S_RESULT;
               end
            end
            S_REG: begin
               if (register_ready_i) begin
                  register_valid_q <= 1'b0;
                  result_ready_q   <= 1'b1;
                  state_q          <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (result_valid_i) begin
                  if (result_id_i == cur_id_q) begin
                     result_ready_q <= 1'b0;
                     done_q         <= 1'b1;
                     wb_we_q        <= result_we_i & wb_flag_q & (result_rd_i != '0) & ~result_exc_i;
                     wb_rd_q        <= result_rd_i;
                     wb_data_q      <= result_data_i;
                     exc_q          <= result_exc_i;
                     exccode_q      <= result_exccode_i;
                     state_q        <= S_IDLE;
                  end else begin
                     // Stray beat is consumed; keep waiting for the matching ID.
                     perr_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign off_busy_o          = (state_q != S_IDLE);
   assign off_illegal_o       = illegal_q;
   assign off_done_o          = done_q;
   assign wb_we_o             = wb_we_q;
   assign wb_rd_o             = wb_rd_q;
   assign wb_data_o           = wb_data_q;
   assign exc_o               = exc_q;
   assign exccode_o           = exccode_q;
   assign protocol_err_o      = perr_q;

   assign issue_valid_o       = issue_valid_q;
   assign issue_instr_o       = instr_q;
   assign issue_id_o          = id_cnt_q;
   assign issue_hartid_o      = HARTID;

   assign commit_valid_o      = commit_valid_q;
   assign commit_id_o         = cur_id_q;
   assign commit_kill_o       = commit_kill_q;

   assign register_valid_o    = register_valid_q;
   assign register_id_o       = cur_id_q;
   assign register_rs_o       = rs_q;
   assign register_rs_valid_o = register_valid_q ? rd_flags_q : '0;

   assign result_ready_o      = result_ready_q;

endmodule
